// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared constants for the pipeline control unit. Holds the
//               stall-bit polarity, exception codes, redirect vectors and
//               the control FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Polarity of a single stall bit.
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Exception codes delivered by MEM.
  localparam logic [31:0] C_EXC_NONE      = 32'h0000_0000;
  localparam logic [31:0] C_EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] C_EXC_ERET      = 32'h0000_000e;

  // Redirect vectors.
  localparam logic [31:0] C_INT_VECTOR = 32'h0000_0020;
  localparam logic [31:0] C_EXC_VECTOR = 32'h0000_0040;

  // Stall vectors; bit0 PC ... bit5 WB.
  localparam logic [5:0] C_STALL_NONE = {6{NoStop}};
  localparam logic [5:0] C_STALL_ALL  = {6{Stop}};
  localparam logic [5:0] C_STALL_ID   = {{3{NoStop}}, {3{Stop}}};
  localparam logic [5:0] C_STALL_EX   = {{2{NoStop}}, {4{Stop}}};
  localparam logic [5:0] C_STALL_MEM  = {NoStop, {5{Stop}}};

  // Control FSM encoding.
  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'd0,
    CTRL_FREEZE = 2'd1,
    CTRL_FLUSH  = 2'd2
  } ctrl_state_t;

  // Redirect target for a given exception code. A zero code means the
  // trigger was a bus timeout, which shares the general exception vector.
  function automatic logic [31:0] redirect_target(input logic [31:0] excepttype,
                                                  input logic [31:0] epc);
    logic [31:0] target;
    target = C_EXC_VECTOR;
    if (excepttype == C_EXC_INTERRUPT) begin
      target = C_INT_VECTOR;
    end else if (excepttype == C_EXC_ERET) begin
      target = epc;
    end
    return target;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous reset, active low
//               inc   - count enable for this cycle
//               count - current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control for the five-stage core. Merges stall
//               requests into a per-stage stall vector, sequences exception
//               flushes (IDLE -> FREEZE -> FLUSH -> IDLE), converts a hung
//               MEM access into an exception via a watchdog, and keeps
//               saturating stall/flush activity counters.
// Ports       : clk, rst (async, active low)
//               stallreq_id/ex/mem - hold requests from ID, EX, MEM
//               excepttype_i       - exception code from MEM (0 = none)
//               cp0_epc_i          - EPC used as eret target
//               stall_o            - per-stage stall, bit0 PC .. bit5 WB
//               flush_o            - registered flush pulse
//               new_pc_o           - redirect target, valid with flush_o
//               bus_timeout_o      - combinational watchdog expiry pulse
//               stall_cycles_o     - saturating stalled-cycle count
//               flush_count_o      - saturating flush count
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WDOG_LIMIT = 255,
  parameter int WDOG_W     = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             bus_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam logic [WDOG_W-1:0] C_WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic [WDOG_W-1:0] r_wdog;
  logic [WDOG_W-1:0] w_wdog_next;
  logic              w_wdog_expire;
  logic              w_exc;
  logic              w_trigger;
  logic [31:0]       r_target;
  logic              r_flush;
  logic [31:0]       r_new_pc;
  logic [5:0]        w_stall;

  assign w_exc = (excepttype_i != C_EXC_NONE);

  // Watchdog only runs in IDLE; expiry is decided on the cycle the counter
  // already sits at the last value and MEM is still waiting.
  assign w_wdog_expire = (r_state == CTRL_IDLE) && stallreq_mem && (r_wdog == C_WDOG_LAST);
  assign w_trigger     = w_exc || w_wdog_expire;

  always_comb begin
    w_wdog_next = '0;
    if ((r_state == CTRL_IDLE) && stallreq_mem && !w_wdog_expire) begin
      w_wdog_next = r_wdog + WDOG_W'(1);
    end
  end

  // Next state and stall vector.
  always_comb begin
    w_next_state = r_state;
    w_stall      = C_STALL_NONE;
    case (r_state)
      CTRL_IDLE: begin
        if (stallreq_mem) begin
          w_stall = C_STALL_MEM;
        end else if (stallreq_ex) begin
          w_stall = C_STALL_EX;
        end else if (stallreq_id) begin
          w_stall = C_STALL_ID;
        end
        if (w_trigger) begin
          w_next_state = CTRL_FREEZE;
        end
      end
      CTRL_FREEZE: begin
        w_stall      = C_STALL_ALL;
        w_next_state = CTRL_FLUSH;
      end
      CTRL_FLUSH: begin
        w_stall      = C_STALL_NONE;
        w_next_state = CTRL_IDLE;
      end
      default: begin
        w_stall      = C_STALL_NONE;
        w_next_state = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CTRL_IDLE;
      r_wdog  <= '0;
    end else begin
      r_state <= w_next_state;
      r_wdog  <= w_wdog_next;
    end
  end

  // Target is captured on IDLE->FREEZE; it moves to the output register on
  // FREEZE->FLUSH so new_pc_o changes together with flush_o and then holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_target <= '0;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
    end else begin
      r_flush <= (r_state == CTRL_FREEZE);
      if ((r_state == CTRL_IDLE) && w_trigger) begin
        r_target <= redirect_target(excepttype_i, cp0_epc_i);
      end
      if (r_state == CTRL_FREEZE) begin
        r_new_pc <= r_target;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall != C_STALL_NONE),
    .count (stall_cycles_o)
  );

  // Leaving FREEZE is exactly the entry into FLUSH.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (r_state == CTRL_FREEZE),
    .count (flush_count_o)
  );

  assign stall_o       = w_stall;
  assign flush_o       = r_flush;
  assign new_pc_o      = r_new_pc;
  assign bus_timeout_o = w_wdog_expire;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. Stimulus pushes the
//               expected per-cycle outputs and expected flush targets into
//               queues; a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int CNT_W = 16;

  typedef struct {
    logic [5:0]       st;
    logic             to;
    logic             fl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic             pcchk;
    logic [31:0]      pc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stallreq_id = 1'b0;
  logic             stallreq_ex = 1'b0;
  logic             stallreq_mem = 1'b0;
  logic [31:0]      excepttype_i = '0;
  logic [31:0]      cp0_epc_i = '0;
  logic [5:0]       stall_o;
  logic             flush_o;
  logic [31:0]      new_pc_o;
  logic             bus_timeout_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] flush_count_o;

  exp_t        cyc_q[$];
  logic [31:0] flush_q[$];
  int          checks = 0;
  int          failures = 0;
  int          sc_model = 0;
  int          fc_model = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .WDOG_LIMIT (4),
    .WDOG_W     (8),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .excepttype_i   (excepttype_i),
    .cp0_epc_i      (cp0_epc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .bus_timeout_o  (bus_timeout_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: falling edge, away from the active edge.
  always @(negedge clk) begin
    if (flush_o === 1'b1) begin
      if (flush_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_flush at %0t: got flush_o=1 new_pc=0x%0h expected no flush",
                 $time, new_pc_o);
      end else begin
        check("flush_target", new_pc_o, flush_q.pop_front());
      end
    end
    if (cyc_q.size() > 0) begin
      exp_t e;
      e = cyc_q.pop_front();
      check("stall_o", 32'(stall_o), 32'(e.st));
      check("bus_timeout_o", 32'(bus_timeout_o), 32'(e.to));
      check("flush_o", 32'(flush_o), 32'(e.fl));
      check("stall_cycles_o", 32'(stall_cycles_o), 32'(e.sc));
      check("flush_count_o", 32'(flush_count_o), 32'(e.fc));
      if (e.pcchk) begin
        check("new_pc_o", new_pc_o, e.pc);
      end
    end
  end

  // One clock of stimulus with its hand-computed expected outputs.
  task automatic cyc(input logic id, input logic ex, input logic mem,
                     input logic [31:0] exc, input logic [31:0] epc,
                     input logic [5:0] st, input logic to, input logic fl,
                     input logic pcchk, input logic [31:0] pc);
    exp_t e;
    @(posedge clk);
    #1;
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    if (fl) begin
      fc_model++;
      flush_q.push_back(pc);
    end
    e.st = st; e.to = to; e.fl = fl;
    e.sc = CNT_W'(sc_model); e.fc = CNT_W'(fc_model);
    e.pcchk = pcchk; e.pc = pc;
    cyc_q.push_back(e);
    if (st != 6'b0) sc_model++;
  endtask

  initial begin
    exp_t r;
    // Reset state.
    r.st = 6'b0; r.to = 1'b0; r.fl = 1'b0; r.sc = '0; r.fc = '0; r.pcchk = 1'b1; r.pc = 32'h0;
    cyc_q.push_back(r);
    @(negedge clk);
    #1 rst = 1'b1;

    // ID + EX together: EX wins, counter 0 -> 3.
    cyc(1, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);
    // ID alone, then MEM over EX, then drop MEM.
    cyc(1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 0, 0, 32'h0);
    cyc(0, 1, 1, 32'h0, 32'h0, 6'b011111, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);

    // General exception 0x8.
    cyc(0, 0, 0, 32'h8, 32'h0, 6'b000000, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b111111, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 1, 1, 32'h40);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 1, 32'h40);

    // eret; an interrupt during FREEZE is ignored.
    cyc(0, 0, 0, 32'he, 32'h1234, 6'b000000, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h1, 32'h5678, 6'b111111, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 1, 1, 32'h1234);
    cyc(0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 0, 1, 32'h1234);
    cyc(0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 0, 1, 32'h1234);

    // Watchdog (limit 4): pulse in the 4th MEM-wait cycle.
    cyc(0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h0, 32'h0, 6'b011111, 1, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h0, 32'h0, 6'b111111, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 1, 1, 32'h40);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);

    // 3-cycle wait, 1-cycle gap, 3-cycle wait: no timeout.
    for (int k = 0; k < 7; k++) begin
      if (k == 3) cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);
      else        cyc(0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 0, 0, 32'h0);
    end
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);

    // Watchdog expiry and interrupt together: interrupt vector wins.
    cyc(0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h1, 32'h0, 6'b011111, 1, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b111111, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 1, 1, 32'h20);
    cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 32'h0);

    // Asynchronous reset in the middle of FREEZE.
    cyc(0, 0, 0, 32'h8, 32'h0, 6'b000000, 0, 0, 0, 32'h0);
    @(posedge clk);
    #1 excepttype_i = 32'h0;
    #1 rst = 1'b0;
    sc_model = 0;
    fc_model = 0;
    r.st = 6'b0; r.to = 1'b0; r.fl = 1'b0; r.sc = '0; r.fc = '0; r.pcchk = 1'b1; r.pc = 32'h0;
    cyc_q.push_back(r);
    @(negedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 0, 1, 32'h0);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("flush_queue_drained", 32'(flush_q.size()), 32'd0);
    check("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no completion expected finish before 100000");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. It merges stall requests from ID, EX and MEM into the per-stage `stall` vector consumed by every pipeline register, including EX/MEM. It also sequences exception flushes through a small FSM and supplies the redirect PC. A bus watchdog turns a hung MEM access into an exception, and two saturating counters record stall and flush activity for debug.

## Interface
Parameters:
- `WDOG_LIMIT`, default 255: consecutive `stallreq_mem` cycles that trigger a bus timeout (legal range 2..2^WDOG_W−1).
- `WDOG_W`, default 8: watchdog counter width.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserted when 0.
- `stallreq_id`  in  1  ID requests a hold (load-use hazard).
- `stallreq_ex`  in  1  EX requests a hold (multi-cycle madd/msub/div).
- `stallreq_mem`  in  1  MEM is waiting on the bus.
- `excepttype_i`  in  32  exception code from MEM; 0 means none.
- `cp0_epc_i`  in  32  current EPC, used for eret.
- `stall_o`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
- `flush_o`  out  1  clears all pipeline registers.
- `new_pc_o`  out  32  redirect target; valid only while `flush_o` = 1.
- `bus_timeout_o`  out  1  one-cycle pulse when the watchdog expires.
- `stall_cycles_o`  out  CNT_W  saturating count of stalled cycles.
- `flush_count_o`  out  CNT_W  saturating count of flushes.

## Operation
- FSM states:
  - IDLE: normal operation.
  - FREEZE: one cycle; the pipeline is held while the flush target is latched.
  - FLUSH: one cycle; the pipeline is cleared and redirected.
- A trigger is `excepttype_i != 0` or watchdog expiry. A trigger seen in IDLE moves the FSM to FREEZE.
- Transitions are fixed: FREEZE→FLUSH→IDLE unconditionally. Triggers seen in FREEZE or FLUSH are ignored, because they come from squashed instructions.
- `stall_o` in IDLE is priority-encoded:
  - `stallreq_mem` → 6'b011111
  - else `stallreq_ex` → 6'b001111
  - else `stallreq_id` → 6'b000111
  - else 6'b000000
- `stall_o` outside IDLE: FREEZE = 6'b111111; FLUSH = 6'b000000.
- The target is latched on the IDLE→FREEZE edge:
  - excepttype 0x1 (interrupt) → 0x00000020
  - excepttype 0xe (eret) → `cp0_epc_i`
  - any other nonzero code, or watchdog expiry → 0x00000040
- If an exception and watchdog expiry occur in the same cycle, the excepttype mapping wins.
- Watchdog counter:
  - Counts consecutive IDLE cycles with `stallreq_mem` = 1.
  - Clears when `stallreq_mem` = 0 or when the FSM is outside IDLE.
  - When the counter equals WDOG_LIMIT−1 and `stallreq_mem` is still 1, it expires: `bus_timeout_o` pulses that same cycle, the counter clears, and the FSM goes to FREEZE.
- `stall_cycles_o` increments in any cycle where `stall_o != 0`, FREEZE included. `flush_count_o` increments on entry to FLUSH. Both saturate at all-ones.

## Timing
- Reset (`rst` = 0, asynchronous):
  - state = IDLE, watchdog = 0, both counters = 0.
  - `flush_o` = 0, `new_pc_o` = 0, `bus_timeout_o` = 0.
  - `stall_o` = 0.
- Reset mid-FREEZE or mid-FLUSH drops the pending redirect, and the counters are lost.
- In IDLE, `stall_o` is combinational from the requests, so it is valid in the same cycle as the request.
- Exception at cycle N: N+1 is FREEZE, N+2 is FLUSH (`flush_o` = 1 and `new_pc_o` valid for exactly that cycle), N+3 is IDLE.
- `flush_o` and `new_pc_o` are registered outputs; `new_pc_o` holds its value after FLUSH.
- `bus_timeout_o` is combinational and lasts one cycle.

## Structure
- Constants in the shared defines header: `Stop`/`NoStop`, excepttype codes, vector addresses 0x20 and 0x40, and state encodings `CTRL_IDLE`/`CTRL_FREEZE`/`CTRL_FLUSH`.
- One sub-module: `sat_counter` (parameter width, `inc` input, saturating), instantiated twice.
- The watchdog stays inline.

## Test plan
- `stallreq_id` and `stallreq_ex` both 1 for 3 cycles → `stall_o` = 6'b001111 each cycle; `stall_cycles_o` goes 0→3.
- `stallreq_mem` = 1 together with `stallreq_ex` = 1 → `stall_o` = 6'b011111. Drop `stallreq_mem` → 6'b001111 in the same cycle.
- `excepttype_i` = 0x8 at cycle N → `stall_o` = 6'b111111 at N+1; at N+2 `flush_o` = 1, `new_pc_o` = 0x40, `stall_o` = 0; back to IDLE at N+3; `flush_count_o` = 1.
- eret (0xe) with `cp0_epc_i` = 0x00001234 → `new_pc_o` = 0x00001234 at N+2. An interrupt (0x1) presented at N+1 is ignored: no second flush.
- `WDOG_LIMIT` = 4 and `stallreq_mem` held high → `bus_timeout_o` pulses in the 4th cycle, then FREEZE, then FLUSH with `new_pc_o` = 0x40. A 3-cycle stall followed by a 1-cycle gap does not time out.
- Assert `rst` = 0 asynchronously during FREEZE → all outputs return to 0 immediately, with no `flush_o` pulse after release.
